// File: rtl/uart_bridge_pkg.sv
// Shared constants and types for the UART-to-bus bridge.
//   CMD_*     : command bytes accepted from the host
//   RSP_*     : response bytes returned to the host
//   RESP_MAX  : longest response (ACK + 4 read-data bytes)
//   bridge_state_t : top-level frame/bus FSM states
package uart_bridge_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;
  localparam int         RESP_MAX  = 5;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} bridge_state_t;
endpackage

// File: rtl/uart_bus_bridge_if.sv
// Single-word peripheral bus between the bridge (master) and a responder (slave).
//   bus_addr/bus_wdata/bus_wen/bus_ren : request, driven by master
//   bus_rdata/bus_stall/bus_error      : response, driven by slave; rdata and
//                                        error are valid when bus_stall is low
interface uart_bus_bridge_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wen;
  logic        bus_ren;
  logic [31:0] bus_rdata;
  logic        bus_stall;
  logic        bus_error;

  modport master (output bus_addr, bus_wdata, bus_wen, bus_ren,
                  input  bus_rdata, bus_stall, bus_error);
  modport slave  (input  bus_addr, bus_wdata, bus_wen, bus_ren,
                  output bus_rdata, bus_stall, bus_error);
endinterface

// File: rtl/uart_bridge_resp_tx.sv
// Response byte queue (up to RESP_MAX bytes) feeding the UART transmitter.
//   load_i/len_i/bytes_i : load a new response, bytes_i[0] sent first
//   tx_data/tx_valid     : byte to transmit, held stable until tx_ready
//   tx_ready             : transmitter accepts when high with tx_valid
//   busy_o               : bytes still queued or in flight
// After each accepted byte tx_valid drops for one cycle before the next byte.
module uart_bridge_resp_tx
  import uart_bridge_pkg::*;
(
  input  logic                        clk,
  input  logic                        nReset,
  input  logic                        load_i,
  input  logic [2:0]                  len_i,
  input  logic [RESP_MAX-1:0][7:0]    bytes_i,
  input  logic                        tx_ready,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  output logic                        busy_o
);
  logic [RESP_MAX-1:0][7:0] q_q;
  logic [2:0]               rem_q;
  logic [7:0]               data_q;
  logic                     vld_q;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      q_q    <= '0;
      rem_q  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (load_i) begin
      q_q    <= bytes_i;
      rem_q  <= len_i;
      vld_q  <= 1'b0;
    end else if (vld_q) begin
      if (tx_ready) vld_q <= 1'b0;
    end else if (rem_q != 3'd0) begin
      data_q <= q_q[0];
      q_q    <= {8'h00, q_q[RESP_MAX-1:1]};
      rem_q  <= rem_q - 3'd1;
      vld_q  <= 1'b1;
    end
  end

  assign tx_data  = data_q;
  assign tx_valid = vld_q;
  assign busy_o   = vld_q || (rem_q != 3'd0);
endmodule

// File: rtl/uart_bus_bridge.sv
// UART-driven bus initiator. Parses CMD + 4 addr bytes (+ 4 data bytes for
// write), issues one bus transaction, then answers ACK/NAK (+ read data).
//   clk, nReset        : clock, async active-low reset
//   rx_data/rx_valid   : received byte strobe, no backpressure
//   tx_data/tx_valid/tx_ready : response byte handshake
//   bus                : bus master port
//   dropped            : pulse when a byte arrives while busy (BUS/RESP)
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int TimeoutCycles = 100000
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  uart_bus_bridge_if.master  bus,
  output logic               dropped
);
  localparam int            CW     = $clog2(TimeoutCycles);
  localparam logic [CW-1:0] TO_MAX = CW'(TimeoutCycles - 1);

  bridge_state_t state_q;
  logic [1:0]    idx_q;
  logic [CW-1:0] to_cnt_q;
  logic          is_write_q;
  logic [31:0]   addr_q, wdata_q;
  logic          wen_q, ren_q, dropped_q;

  logic                     resp_load;
  logic [2:0]               resp_len;
  logic [RESP_MAX-1:0][7:0] resp_bytes;
  logic                     resp_busy;

  // Response is built in the cycle that decides it, so read data goes
  // straight into the queue without a separate capture register.
  always_comb begin
    resp_load  = 1'b0;
    resp_len   = 3'd1;
    resp_bytes = {32'h0, RSP_NAK};
    case (state_q)
      IDLE: if (rx_valid && rx_data != CMD_WRITE && rx_data != CMD_READ) resp_load = 1'b1;
      BUS: if (!bus.bus_stall) begin
        resp_load = 1'b1;
        if (!bus.bus_error) begin
          if (is_write_q) resp_bytes = {32'h0, RSP_ACK};
          else begin
            resp_bytes = {bus.bus_rdata, RSP_ACK};
            resp_len   = 3'd5;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      to_cnt_q   <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      dropped_q <= rx_valid && (state_q == BUS || state_q == RESP);
      case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          idx_q    <= '0;
          if (rx_valid) begin
            if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
              is_write_q <= (rx_data == CMD_WRITE);
              state_q    <= ADDR;
            end else begin
              state_q <= RESP;
            end
          end
        end
        ADDR, DATA: begin
          // A byte on the expiry cycle still counts: rx_valid is tested first.
          if (rx_valid) begin
            to_cnt_q <= '0;
            idx_q    <= idx_q + 2'd1;
            if (state_q == ADDR) addr_q  <= {rx_data, addr_q[31:8]};
            else                 wdata_q <= {rx_data, wdata_q[31:8]};
            if (idx_q == 2'd3) begin
              if (state_q == DATA || !is_write_q) begin
                state_q <= BUS;
                wen_q   <= is_write_q;
                ren_q   <= !is_write_q;
              end else begin
                state_q <= DATA;
              end
            end
          end else if (to_cnt_q == TO_MAX) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            idx_q    <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        BUS: if (!bus.bus_stall) begin
          wen_q   <= 1'b0;
          ren_q   <= 1'b0;
          state_q <= RESP;
        end
        RESP: if (!resp_busy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_bridge_resp_tx u_resp (
    .clk      (clk),
    .nReset   (nReset),
    .load_i   (resp_load),
    .len_i    (resp_len),
    .bytes_i  (resp_bytes),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .busy_o   (resp_busy)
  );

  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_wen   = wen_q;
  assign bus.bus_ren   = ren_q;
  assign dropped       = dropped_q;
endmodule
